// File: rtl/bt_cmd_filter.sv
// Command qualifier for the Bluetooth UART receiver outputs.
// The receiver updates choice/dir one frame bit at a time, so the combined
// code passes through intermediate values mid-frame. A code is accepted only
// after it has been stable for STABLE_CYC cycles. Accepting a nonzero code
// issues a one-cycle command strobe, and accepting zero issues a release
// strobe. Movement commands (choice 011 or 100) auto-repeat every REPEAT_CYC
// cycles while they remain accepted.
module bt_cmd_filter #(
    parameter int STABLE_CYC = 20834,
    parameter int REPEAT_CYC = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] choice,
    input  logic [1:0] dir,
    output logic       cmd_valid,
    output logic [2:0] cmd_choice,
    output logic [1:0] cmd_dir,
    output logic       cmd_repeat,
    output logic       cmd_release,
    output logic       active
);

    localparam logic [15:0] STAB_MAX = 16'(STABLE_CYC - 1);
    localparam logic [24:0] REP_MAX  = 25'(REPEAT_CYC - 1);

    logic [4:0]  code_in;
    logic [4:0]  cand;
    logic [4:0]  acc;
    logic [15:0] stab_cnt;
    logic [24:0] rep_cnt;
    logic        accept;
    logic        is_move;
    logic        rep_wrap;

    // Accept and repeat-wrap decode. When both occur on the same edge,
    // the accept takes precedence wherever the two are combined below.
    always_comb begin
        code_in  = {choice, dir};
        accept   = (code_in == cand) && (stab_cnt == STAB_MAX) && (cand != acc);
        is_move  = (acc[4:2] == 3'b011) || (acc[4:2] == 3'b100);
        rep_wrap = is_move && (rep_cnt == REP_MAX);
    end

    // Candidate tracking. Any change restarts the stability count, and the
    // count saturates so that a long-held code never wraps back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= 5'd0;
            stab_cnt <= 16'd0;
        end else if (code_in != cand) begin
            cand     <= code_in;
            stab_cnt <= 16'd0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 16'd1;
        end
    end

    // Accepted code and repeat timer. The timer runs only for movement codes
    // and restarts whenever a new code is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= 5'd0;
            rep_cnt <= 25'd0;
        end else begin
            if (accept) begin
                acc <= cand;
            end
            if (accept || !is_move || rep_wrap) begin
                rep_cnt <= 25'd0;
            end else begin
                rep_cnt <= rep_cnt + 25'd1;
            end
        end
    end

    // Registered strobes. cmd_choice/cmd_dir keep the last issued command
    // between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid   <= 1'b0;
            cmd_choice  <= 3'd0;
            cmd_dir     <= 2'd0;
            cmd_repeat  <= 1'b0;
            cmd_release <= 1'b0;
            active      <= 1'b0;
        end else begin
            cmd_valid   <= (accept && (cand != 5'd0)) || (!accept && rep_wrap);
            cmd_repeat  <= !accept && rep_wrap;
            cmd_release <= accept && (cand == 5'd0);
            active      <= accept ? (cand != 5'd0) : (acc != 5'd0);
            if (accept && (cand != 5'd0)) begin
                cmd_choice <= cand[4:2];
                cmd_dir    <= cand[1:0];
            end else if (!accept && rep_wrap) begin
                cmd_choice <= acc[4:2];
                cmd_dir    <= acc[1:0];
            end
        end
    end

endmodule

// File: tb/tb_bt_cmd_filter.sv
// Directed bench for bt_cmd_filter with STABLE_CYC=4, REPEAT_CYC=10.
// Edge numbering: edge 1 is the first rising edge after reset release. A
// code that is driven before edge N and then held is accepted at edge N+4.
// The outputs are sampled 1 ns after each edge.
module tb_bt_cmd_filter;

    logic       clk;
    logic       rst_n;
    logic [4:0] code;
    logic [2:0] choice;
    logic [1:0] dir;
    logic       cmd_valid;
    logic [2:0] cmd_choice;
    logic [1:0] cmd_dir;
    logic       cmd_repeat;
    logic       cmd_release;
    logic       active;

    int errors = 0;
    int checks = 0;

    assign choice = code[4:2];
    assign dir    = code[1:0];

    bt_cmd_filter #(
        .STABLE_CYC(4),
        .REPEAT_CYC(10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .choice     (choice),
        .dir        (dir),
        .cmd_valid  (cmd_valid),
        .cmd_choice (cmd_choice),
        .cmd_dir    (cmd_dir),
        .cmd_repeat (cmd_repeat),
        .cmd_release(cmd_release),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the DUT in reset for three cycles with code v applied, then
    // release it on a falling edge so that the next rising edge is edge 1.
    task automatic apply_reset(input logic [4:0] v);
        rst_n = 1'b0;
        code  = v;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        code  = 5'b10001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cmd_valid, cmd_choice, cmd_dir, cmd_repeat, cmd_release, active} !== 9'd0)
                begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0", i,
                         {cmd_valid, cmd_choice, cmd_dir, cmd_repeat, cmd_release, active});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if (cmd_valid !== (t == 5)) begin
                errors++;
                $display("FAIL reset_first_cmd edge=%0d got=%b want=%b", t, cmd_valid, (t == 5));
            end
            if (t == 5) begin
                checks++;
                if ({cmd_choice, cmd_dir, cmd_repeat, active} !== 7'b100_01_0_1) begin
                    errors++;
                    $display("FAIL reset_first_code got=%b want=1000101",
                             {cmd_choice, cmd_dir, cmd_repeat, active});
                end
            end
        end
    endtask

    // The frame bits arrive one at a time; only the final value 01101 is
    // held long enough to be accepted. It is accepted at edge 7+4=11 and
    // then repeats at edges 21 and 31.
    task automatic test_frame_arrival();
        logic exp_v;
        apply_reset(5'b00001);
        for (int t = 1; t <= 36; t++) begin
            code = (t <= 2) ? 5'b00001 : (t <= 4) ? 5'b00011 : (t <= 6) ? 5'b01111 : 5'b01101;
            tick();
            exp_v = (t == 11) || (t == 21) || (t == 31);
            checks++;
            if (cmd_valid !== exp_v || cmd_repeat !== (exp_v && t != 11)) begin
                errors++;
                $display("FAIL frame_strobe edge=%0d got v=%b r=%b want v=%b r=%b", t,
                         cmd_valid, cmd_repeat, exp_v, (exp_v && t != 11));
            end
            if (exp_v) begin
                checks++;
                if ({cmd_choice, cmd_dir} !== 5'b01101) begin
                    errors++;
                    $display("FAIL frame_code edge=%0d got=%b want=01101", t, {cmd_choice, cmd_dir});
                end
            end
        end
    endtask

    // Non-movement code 00100 is accepted at edge 5 and does not repeat.
    // Dropping to zero before edge 41 produces a release at edge 45.
    task automatic test_non_move_and_release();
        apply_reset(5'b00100);
        for (int t = 1; t <= 48; t++) begin
            code = (t <= 40) ? 5'b00100 : 5'b00000;
            tick();
            checks++;
            if (cmd_valid !== (t == 5) || cmd_repeat !== 1'b0) begin
                errors++;
                $display("FAIL nonmove_strobe edge=%0d got v=%b r=%b want v=%b r=0", t,
                         cmd_valid, cmd_repeat, (t == 5));
            end
            checks++;
            if (active !== (t >= 5 && t < 45)) begin
                errors++;
                $display("FAIL nonmove_active edge=%0d got=%b want=%b", t, active,
                         (t >= 5 && t < 45));
            end
            checks++;
            if (cmd_release !== (t == 45)) begin
                errors++;
                $display("FAIL release_strobe edge=%0d got=%b want=%b", t, cmd_release, (t == 45));
            end
            if (t == 5) begin
                checks++;
                if ({cmd_choice, cmd_dir} !== 5'b00100) begin
                    errors++;
                    $display("FAIL nonmove_code got=%b want=00100", {cmd_choice, cmd_dir});
                end
            end
        end
    endtask

    // Code 10010 is accepted at edge 5 and repeats at edges 15 and 25. A
    // glitch to 10000 on edges 8 and 9 settles back to the accepted code,
    // so it must not produce a strobe or shift the repeat timing.
    task automatic test_glitch();
        logic exp_v;
        apply_reset(5'b10010);
        for (int t = 1; t <= 30; t++) begin
            code = (t == 8 || t == 9) ? 5'b10000 : 5'b10010;
            tick();
            exp_v = (t == 5) || (t == 15) || (t == 25);
            checks++;
            if (cmd_valid !== exp_v || cmd_repeat !== (exp_v && t != 5)) begin
                errors++;
                $display("FAIL glitch_strobe edge=%0d got v=%b r=%b want v=%b r=%b", t,
                         cmd_valid, cmd_repeat, exp_v, (exp_v && t != 5));
            end
            if (exp_v) begin
                checks++;
                if ({cmd_choice, cmd_dir} !== 5'b10010) begin
                    errors++;
                    $display("FAIL glitch_code edge=%0d got=%b want=10010", t, {cmd_choice, cmd_dir});
                end
            end
        end
    endtask

    // Code 01100 is accepted at edge 5 and repeats at edge 15. The new code
    // 10011 is driven from edge 21, so it is accepted at edge 25, which is
    // also the next repeat wrap. The result must be one non-repeat strobe
    // carrying 10011, followed by a repeat at edge 35.
    task automatic test_collision();
        logic       exp_v;
        logic       exp_r;
        logic [4:0] exp_c;
        apply_reset(5'b01100);
        for (int t = 1; t <= 40; t++) begin
            code = (t <= 20) ? 5'b01100 : 5'b10011;
            tick();
            exp_v = (t == 5) || (t == 15) || (t == 25) || (t == 35);
            exp_r = (t == 15) || (t == 35);
            exp_c = (t < 25) ? 5'b01100 : 5'b10011;
            checks++;
            if (cmd_valid !== exp_v || cmd_repeat !== exp_r) begin
                errors++;
                $display("FAIL collide_strobe edge=%0d got v=%b r=%b want v=%b r=%b", t,
                         cmd_valid, cmd_repeat, exp_v, exp_r);
            end
            if (exp_v) begin
                checks++;
                if ({cmd_choice, cmd_dir} !== exp_c) begin
                    errors++;
                    $display("FAIL collide_code edge=%0d got=%b want=%b", t, {cmd_choice, cmd_dir}, exp_c);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        code  = 5'd0;
        test_reset();
        test_frame_arrival();
        test_non_move_and_release();
        test_glitch();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
